// File: rtl/pulse_capture_pkg.sv
// Shared types and helpers for the pulse_capture block.
package pulse_capture_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        READOUT
    } state_e;

    localparam int unsigned MISSED_W = 16;
    localparam int unsigned SAT_W    = 32;

    function automatic int unsigned IDX_W(input int unsigned win_len);
        return (win_len > 1) ? $clog2(win_len) : 1;
    endfunction

    // Callers zero-extend to SAT_W and truncate the result back to sample width.
    function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b);
        return (a >= b) ? a - b : '0;
    endfunction

endpackage

// File: rtl/pulse_capture_if.sv
// Waveform readout stream (valid/ready) between pulse_capture and its consumer.
interface pulse_capture_if #(
    parameter int unsigned DATA_W = 14
);
    logic [DATA_W-1:0] wf_data;
    logic              wf_valid;
    logic              wf_ready;
    logic              wf_last;

    modport master (output wf_data, output wf_valid, output wf_last, input wf_ready);
    modport slave  (input wf_data, input wf_valid, input wf_last, output wf_ready);
endinterface

// File: rtl/sample_delay_line.sv
// Fixed-depth shift pipeline: dout is din from exactly DEPTH cycles earlier, zero after reset.
module sample_delay_line #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned DEPTH  = 6
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] pipe_q [DEPTH];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
        end
    end

    assign dout = pipe_q[DEPTH-1];
endmodule

// File: rtl/pulse_capture.sv
// Triggered waveform recorder: pre-trigger delay, WIN_LEN capture, pedestal/peak extraction, stream readout.
// Define PULSE_CAPTURE_PED_AVG_EN to average the pedestal over 2**PED_LOG2 samples.
module pulse_capture
    import pulse_capture_pkg::*;
#(
    parameter int unsigned DATA_W   = 14,
    parameter int unsigned PRE_DLY  = 6,
    parameter int unsigned WIN_LEN  = 32,
    parameter int unsigned PED_LOG2 = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [DATA_W-1:0]   adc_in,
    input  logic                trigger_in,
    output logic                long_trigger,
    output logic [DATA_W-1:0]   pulse_height,
    output logic [DATA_W-1:0]   pedestal,
    output logic                pulse_valid,
    output logic                busy,
    output logic [MISSED_W-1:0] missed_count,
    pulse_capture_if.master     wf
);
    localparam int unsigned     IW       = IDX_W(WIN_LEN);
    localparam logic [IW-1:0]   LAST_IDX = IW'(WIN_LEN - 1);

    if (PRE_DLY < 1 || PRE_DLY > 64 || WIN_LEN < 4 || WIN_LEN > 1024 ||
        (WIN_LEN & (WIN_LEN - 1)) != 0 || PED_LOG2 > 8) begin : g_bad_cfg
        $error("pulse_capture: unsupported parameter set");
    end

    logic [DATA_W-1:0] d;
    logic [DATA_W-1:0] ped_sample;

    sample_delay_line #(.DATA_W(DATA_W), .DEPTH(PRE_DLY)) u_pre_dly (
        .clk(clk), .reset_n(reset_n), .din(adc_in), .dout(d)
    );

`ifdef PULSE_CAPTURE_PED_AVG_EN
    localparam int unsigned SUM_W = DATA_W + PED_LOG2;
    logic [DATA_W-1:0] d_old;
    logic [SUM_W-1:0]  sum_q, sum_d;

    sample_delay_line #(.DATA_W(DATA_W), .DEPTH(1 << PED_LOG2)) u_ped_win (
        .clk(clk), .reset_n(reset_n), .din(d), .dout(d_old)
    );

    // Sum runs every cycle; freezing happens on the pedestal register, which only loads in IDLE.
    assign sum_d      = sum_q + SUM_W'(d) - SUM_W'(d_old);
    assign ped_sample = DATA_W'(sum_d >> PED_LOG2);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sum_q <= '0;
        else          sum_q <= sum_d;
    end
`else
    assign ped_sample = d;
`endif

    state_e              state_q;
    logic                trigger_q;
    logic [IW-1:0]       idx_q;
    logic [DATA_W-1:0]   ped_q, peak_q;
    logic                long_trigger_q, pulse_valid_q;
    logic [DATA_W-1:0]   pulse_height_q, pedestal_q;
    logic [DATA_W-1:0]   wf_data_q;
    logic                wf_valid_q, wf_last_q;
    logic [MISSED_W-1:0] missed_q;
    logic [DATA_W-1:0]   wave_q [WIN_LEN];

    logic                trig_rise, handshake, wr_en;
    logic [IW-1:0]       rd_next, wr_idx;
    logic [DATA_W-1:0]   peak_d;

    assign trig_rise = trigger_in & ~trigger_q;
    assign handshake = wf_valid_q & wf.wf_ready;
    assign rd_next   = idx_q + 1'b1;
    assign peak_d    = (d > peak_q) ? d : peak_q;
    assign wr_en     = ((state_q == IDLE) && trig_rise) || (state_q == CAPTURE);
    assign wr_idx    = (state_q == CAPTURE) ? idx_q : '0;

    always_ff @(posedge clk) begin
        if (wr_en) wave_q[wr_idx] <= d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            trigger_q      <= 1'b0;
            idx_q          <= '0;
            ped_q          <= '0;
            peak_q         <= '0;
            long_trigger_q <= 1'b0;
            pulse_valid_q  <= 1'b0;
            pulse_height_q <= '0;
            pedestal_q     <= '0;
            wf_data_q      <= '0;
            wf_valid_q     <= 1'b0;
            wf_last_q      <= 1'b0;
            missed_q       <= '0;
        end else begin
            trigger_q     <= trigger_in;
            pulse_valid_q <= 1'b0;
            if (trig_rise && (state_q != IDLE) && (missed_q != '1))
                missed_q <= missed_q + 1'b1;

            case (state_q)
                IDLE: begin
                    if (trig_rise) begin
                        state_q        <= CAPTURE;
                        idx_q          <= IW'(1);
                        peak_q         <= d;
                        long_trigger_q <= 1'b1;
                    end else begin
                        ped_q <= ped_sample;
                    end
                end
                CAPTURE: begin
                    peak_q <= peak_d;
                    if (idx_q == LAST_IDX) begin
                        state_q        <= READOUT;
                        idx_q          <= '0;
                        pulse_height_q <= DATA_W'(sat_sub(SAT_W'(peak_d), SAT_W'(ped_q)));
                        pedestal_q     <= ped_q;
                        pulse_valid_q  <= 1'b1;
                        wf_valid_q     <= 1'b1;
                        wf_data_q      <= wave_q[0];
                        wf_last_q      <= 1'b0;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                READOUT: begin
                    // long_trigger spans WIN_LEN cycles, so it drops after the first READOUT cycle.
                    long_trigger_q <= 1'b0;
                    if (handshake) begin
                        if (wf_last_q) begin
                            state_q    <= IDLE;
                            idx_q      <= '0;
                            wf_valid_q <= 1'b0;
                            wf_last_q  <= 1'b0;
                        end else begin
                            idx_q     <= rd_next;
                            wf_data_q <= wave_q[rd_next];
                            wf_last_q <= (rd_next == LAST_IDX);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign long_trigger = long_trigger_q;
    assign pulse_height = pulse_height_q;
    assign pedestal     = pedestal_q;
    assign pulse_valid  = pulse_valid_q;
    assign busy         = (state_q != IDLE);
    assign missed_count = missed_q;
    assign wf.wf_data   = wf_data_q;
    assign wf.wf_valid  = wf_valid_q;
    assign wf.wf_last   = wf_last_q;
endmodule

// File: tb/tb_pulse_capture.sv
// Self-checking bench for pulse_capture: directed and randomised windows against a window-level model.
module tb_pulse_capture;
    localparam int unsigned DATA_W   = 14;
    localparam int unsigned PRE_DLY  = 6;
    localparam int unsigned WIN_LEN  = 32;
    localparam int unsigned PED_LOG2 = 2;
    localparam int          MASK     = (1 << DATA_W) - 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [DATA_W-1:0] adc_in;
    logic              trigger_in;
    logic              long_trigger, pulse_valid, busy;
    logic [DATA_W-1:0] pulse_height, pedestal;
    logic [15:0]       missed_count;

    pulse_capture_if #(.DATA_W(DATA_W)) wf_if ();

    pulse_capture #(
        .DATA_W(DATA_W), .PRE_DLY(PRE_DLY), .WIN_LEN(WIN_LEN), .PED_LOG2(PED_LOG2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .adc_in(adc_in), .trigger_in(trigger_in),
        .long_trigger(long_trigger), .pulse_height(pulse_height), .pedestal(pedestal),
        .pulse_valid(pulse_valid), .busy(busy), .missed_count(missed_count), .wf(wf_if)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    int adc_hist[int];
    int exp_missed = 0;
    int extra_rises[$];
    int last_pv_cyc = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Delayed sample seen by the capture logic in cycle c (cycles counted from reset release).
    function automatic int d_of(input int c);
        if (c < int'(PRE_DLY) || !adc_hist.exists(c - int'(PRE_DLY))) return 0;
        return adc_hist[c - int'(PRE_DLY)];
    endfunction

    function automatic int exp_ped(input int t);
`ifdef PULSE_CAPTURE_PED_AVG_EN
        int s = 0;
        for (int k = 1; k <= (1 << PED_LOG2); k++) s += d_of(t - k);
        return s >> PED_LOG2;
`else
        return d_of(t - 1);
`endif
    endfunction

    task automatic tick(input int a, input logic trig, input logic rdy);
        adc_in          = DATA_W'(a);
        trigger_in      = trig;
        wf_if.wf_ready  = rdy;
        adc_hist[cyc]   = a & MASK;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        reset_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0;
        adc_hist.delete();
        exp_missed = 0;
    endtask

    // kind 0: ramp of cycle count; 1: baseline+5-sample step at adc offset ps; 2: alternating base/base+4
    task automatic run_window(input int pre, input int kind, input int base, input int amp,
                              input int ps, input int noise, input int rmode, input string tag);
        int T, H, wc, stall, rel, a, nrx;
        int pv_cnt, pv_ped, pv_h, lt_cnt, lt_first;
        int busy_err, stab_err, data_err, last_err;
        int peak, ped, h, prev_data;
        logic trig, rdy, prev_hold, prev_last, exp_busy;
        T = cyc + pre; H = -1; wc = 0; stall = 0; nrx = 0;
        pv_cnt = 0; pv_ped = 0; pv_h = 0; lt_cnt = 0; lt_first = -1;
        busy_err = 0; stab_err = 0; data_err = 0; last_err = 0;
        prev_hold = 1'b0; prev_data = 0; prev_last = 1'b0;
        while (cyc < T + 600 && !(H >= 0 && cyc > H + 4)) begin
            rel = cyc - T;
            case (kind)
                0:       a = cyc;
                1:       a = ((rel >= ps && rel < ps + 5) ? base + amp : base)
                             + ((noise > 0) ? int'($urandom_range(0, noise)) : 0);
                default: a = base + 4 * (cyc % 2);
            endcase
            a = a & MASK;
            trig = (rel == 0);
            foreach (extra_rises[i]) if (extra_rises[i] == rel) trig = 1'b1;
            case (rmode)
                0: rdy = 1'b1;
                1: if (cyc >= T + int'(WIN_LEN) && H < 0 && wc == 7 && stall < 10) begin
                       rdy = 1'b0; stall++;
                   end else rdy = (cyc % 2 == 0);
                default: rdy = 1'($urandom_range(0, 1));
            endcase

            if (pulse_valid === 1'b1) begin
                pv_cnt++; last_pv_cyc = cyc; pv_ped = int'(pedestal); pv_h = int'(pulse_height);
            end
            if (long_trigger === 1'b1) begin
                lt_cnt++;
                if (lt_first < 0) lt_first = cyc;
            end
            exp_busy = (cyc >= T + 1) && (H < 0 || cyc <= H);
            if (busy !== exp_busy) busy_err++;
            if (prev_hold && (wf_if.wf_valid !== 1'b1 || int'(wf_if.wf_data) != prev_data ||
                              wf_if.wf_last !== prev_last)) stab_err++;
            if (wf_if.wf_valid === 1'b1 && rdy) begin
                if (int'(wf_if.wf_data) != d_of(T + nrx)) data_err++;
                if (wf_if.wf_last !== (nrx == int'(WIN_LEN) - 1)) last_err++;
                nrx++;
            end
            prev_hold = (wf_if.wf_valid === 1'b1) && !rdy;
            prev_data = int'(wf_if.wf_data);
            prev_last = wf_if.wf_last;
            if (cyc >= T + int'(WIN_LEN) && H < 0 && rdy) begin
                wc++;
                if (wc == int'(WIN_LEN)) H = cyc;
            end
            tick(a, trig, rdy);
        end

        peak = 0;
        for (int i = 0; i < int'(WIN_LEN); i++) if (d_of(T + i) > peak) peak = d_of(T + i);
        ped = exp_ped(T);
        h = (peak >= ped) ? peak - ped : 0;
        foreach (extra_rises[i])
            if (H >= 0 && extra_rises[i] >= 1 && T + extra_rises[i] <= H && exp_missed < 65535)
                exp_missed++;

        chk({tag, ".done"},          32'(H >= 0), 1);
        chk({tag, ".pv_count"},      pv_cnt, 1);
        chk({tag, ".pv_latency"},    last_pv_cyc - T, WIN_LEN);
        chk({tag, ".pedestal"},      pv_ped, ped);
        chk({tag, ".pulse_height"},  pv_h, h);
        chk({tag, ".long_trig_len"}, lt_cnt, WIN_LEN);
        chk({tag, ".long_trig_start"}, lt_first - T, 1);
        chk({tag, ".words"},         nrx, WIN_LEN);
        chk({tag, ".data_err"},      data_err, 0);
        chk({tag, ".last_err"},      last_err, 0);
        chk({tag, ".stall_err"},     stab_err, 0);
        chk({tag, ".busy_err"},      busy_err, 0);
        chk({tag, ".missed"},        32'(missed_count), exp_missed);
    endtask

    initial begin
        int t0;
        reset_n = 1'b0; adc_in = '0; trigger_in = 1'b0; wf_if.wf_ready = 1'b0;
        #2;
        chk("rst.busy", 32'(busy), 0);
        chk("rst.outs", {26'(0), long_trigger, pulse_valid, wf_if.wf_valid, wf_if.wf_last,
                         |pulse_height, |pedestal}, 0);
        chk("rst.missed", 32'(missed_count), 0);
        do_reset(2);

        run_window(100, 0, 0, 0, 0, 0, 0, "ramp");
        chk("ramp.pv_abs", last_pv_cyc, 132);

        run_window(12, 1, 100, 300, 8, 0, 0, "step");
        run_window(12, 1, 500, -300, 8, 0, 0, "dip");
        run_window(12, 1, int'($urandom_range(50, 3000)), int'($urandom_range(0, 3000)),
                   int'($urandom_range(0, 25)), 7, 1, "stall");

        extra_rises = {10, 40};
        run_window(12, 1, 300, 700, 4, 3, 0, "miss");
        extra_rises.delete();
        run_window(12, 1, 250, 900, 20, 3, 0, "fresh");

        extra_rises = {63};
        run_window(12, 1, 150, 200, 2, 0, 0, "b2b");
        extra_rises.delete();

        t0 = cyc + 12;
        while (cyc < t0 + 15) tick(400 + cyc % 3, (cyc == t0), 1'b1);
        reset_n = 1'b0;
        #1;
        chk("midrst.busy", 32'(busy), 0);
        chk("midrst.outs", {26'(0), long_trigger, pulse_valid, wf_if.wf_valid, wf_if.wf_last,
                            |pulse_height, |pedestal}, 0);
        chk("midrst.missed", 32'(missed_count), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        cyc = 0; adc_hist.delete(); exp_missed = 0;

        run_window(12, 2, 100, 0, 0, 0, 0, "alt");

        repeat (4)
            run_window(int'($urandom_range(8, 20)), 1, int'($urandom_range(50, 3000)),
                       int'($urandom_range(0, 3000)) - 40, int'($urandom_range(0, 30)),
                       int'($urandom_range(0, 15)), 2, "rand");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
